pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed-width inter-stage registers (IF/ID, ID/EX, EX/MEM) with one generic block. Each stage splits its payload into a control field and a data field, and supports bubble insertion (hazard stall) and flush (taken branch/jump). Backpressure is decoupled so `in_ready` never depends combinationally on `out_ready`.

---
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register: valid/ready handshake, two-entry skid buffer,
// bubble insertion and flush. Define PIPE_STATS_EN to add saturating stats counters.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 19,
  parameter int unsigned DATA_W = 191
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              ready_q;
  logic [1:0]        occ_q;

  logic              main_v_n, skid_v_n;
  logic [CTRL_W-1:0] main_ctrl_n, skid_ctrl_n;
  logic [DATA_W-1:0] main_data_n, skid_data_n;

  logic              w_bubble, w_in, w_v, drain;
  logic [CTRL_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_data;

  // Write request: flush beats bubble beats input; a bubble only lands while ready.
  always_comb begin
    w_bubble = bubble && ready_q && !flush;
    w_in     = in_valid && ready_q && !bubble && !flush;
    w_v      = w_bubble || w_in;
    w_ctrl   = w_in ? in_ctrl : '0;
    w_data   = w_in ? in_data : '0;
    drain    = main_v && out_ready && !flush;
  end

  always_comb begin
    main_v_n    = main_v;
    main_ctrl_n = main_ctrl;
    main_data_n = main_data;
    skid_v_n    = skid_v;
    skid_ctrl_n = skid_ctrl;
    skid_data_n = skid_data;
    if (flush) begin
      main_v_n    = 1'b0;
      main_ctrl_n = '0;
      main_data_n = '0;
      skid_v_n    = 1'b0;
      skid_ctrl_n = '0;
      skid_data_n = '0;
    end else if (!main_v || drain) begin
      if (skid_v) begin
        // Skid always refills main first so ordering stays FIFO.
        main_v_n    = 1'b1;
        main_ctrl_n = skid_ctrl;
        main_data_n = skid_data;
        skid_v_n    = 1'b0;
        skid_ctrl_n = '0;
      end else if (w_v) begin
        main_v_n    = 1'b1;
        main_ctrl_n = w_ctrl;
        main_data_n = w_data;
      end else begin
        main_v_n    = 1'b0;
        main_ctrl_n = '0;
      end
    end else if (!skid_v && w_v) begin
      skid_v_n    = 1'b1;
      skid_ctrl_n = w_ctrl;
      skid_data_n = w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v    <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_v    <= 1'b0;
      skid_ctrl <= '0;
      skid_data <= '0;
      ready_q   <= 1'b1;
      occ_q     <= '0;
    end else begin
      main_v    <= main_v_n;
      main_ctrl <= main_ctrl_n;
      main_data <= main_data_n;
      skid_v    <= skid_v_n;
      skid_ctrl <= skid_ctrl_n;
      skid_data <= skid_data_n;
      ready_q   <= ~skid_v_n;
      occ_q     <= {1'b0, main_v_n} + {1'b0, skid_v_n};
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = occ_q;

`ifdef PIPE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (w_bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 16'd1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
      if (main_v && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid; stats checks are compiled in with PIPE_STATS_EN.
module tb_pipe_stage_skid;
  localparam int unsigned CW = 19;
  localparam int unsigned DW = 191;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, bubble, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STATS_EN
  logic [15:0]   bubble_cnt, flush_cnt, stall_cnt;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .bubble(bubble), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STATS_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] dpat(input logic [7:0] k);
    return {k, 175'd0, k};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] k);
    in_valid = v;
    in_ctrl  = CW'(k);
    in_data  = dpat(k);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] k, input logic [1:0] occ);
    chk({tag, "_valid"}, DW'(out_valid), DW'(v));
    chk({tag, "_ctrl"}, DW'(out_ctrl), DW'(CW'(k)));
    chk({tag, "_occ"}, DW'(occupancy), DW'(occ));
  endtask

  initial begin
    rst = 1'b1; bubble = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 8'h05);
    step; step;
    chk("rst_valid", DW'(out_valid), DW'(1'b0));
    chk("rst_ctrl", DW'(out_ctrl), '0);
    chk("rst_ready", DW'(in_ready), DW'(1'b1));
    chk("rst_occ", DW'(occupancy), '0);
    rst = 1'b0;
    step;
    chk_out("post_rst", 1'b1, 8'h05, 2'd1);
    chk("post_rst_data", out_data, dpat(8'h05));
    drive(1'b0, 8'h00);
    step;
    chk_out("drain", 1'b0, 8'h00, 2'd0);

    // Streaming A..D
    for (int unsigned k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'hA0 + k));
      step;
      chk_out("stream", 1'b1, 8'(8'hA0 + k), 2'd1);
      chk("stream_data", out_data, dpat(8'(8'hA0 + k)));
    end
    drive(1'b0, 8'h00);
    step;
    chk_out("stream_end", 1'b0, 8'h00, 2'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 8'h11); step;
    chk_out("bp_a", 1'b1, 8'h11, 2'd1);
    chk("bp_a_ready", DW'(in_ready), DW'(1'b1));
    drive(1'b1, 8'h22); step;
    chk_out("bp_b", 1'b1, 8'h11, 2'd2);
    chk("bp_b_ready", DW'(in_ready), DW'(1'b0));
    drive(1'b1, 8'h33); step;
    chk_out("bp_hold", 1'b1, 8'h11, 2'd2);
    out_ready = 1'b1;
    step;
    chk_out("bp_out_b", 1'b1, 8'h22, 2'd1);
    chk("bp_out_b_ready", DW'(in_ready), DW'(1'b1));
    step;
    chk_out("bp_out_c", 1'b1, 8'h33, 2'd1);
    chk("bp_out_c_data", out_data, dpat(8'h33));
    drive(1'b0, 8'h00); step;
    chk_out("bp_end", 1'b0, 8'h00, 2'd0);

    // Bubble ahead of X
    drive(1'b1, 8'h77);
    bubble = 1'b1; step;
    chk_out("bub", 1'b1, 8'h00, 2'd1);
    chk("bub_data", out_data, '0);
    bubble = 1'b0; step;
    chk_out("bub_x", 1'b1, 8'h77, 2'd1);
    chk("bub_x_data", out_data, dpat(8'h77));
    drive(1'b0, 8'h00); step;
`ifdef PIPE_STATS_EN
    chk("bubble_cnt", DW'(bubble_cnt), DW'(16'd1));
`endif

    // Flush with two held entries and a live input
    out_ready = 1'b0;
    drive(1'b1, 8'h44); step;
    drive(1'b1, 8'h55); step;
    chk_out("fl_full", 1'b1, 8'h44, 2'd2);
    drive(1'b1, 8'hEE);
    flush = 1'b1; step;
    chk_out("fl", 1'b0, 8'h00, 2'd0);
    chk("fl_data", out_data, '0);
    chk("fl_ready", DW'(in_ready), DW'(1'b1));
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 8'h00); step;
    chk_out("fl_dropped", 1'b0, 8'h00, 2'd0);
    flush = 1'b1; bubble = 1'b1; step;
    chk_out("fl_bub", 1'b0, 8'h00, 2'd0);
    flush = 1'b0; bubble = 1'b0; step;
    chk_out("fl_bub_after", 1'b0, 8'h00, 2'd0);
`ifdef PIPE_STATS_EN
    chk("flush_cnt", DW'(flush_cnt), DW'(16'd2));
    chk("bubble_cnt_fl", DW'(bubble_cnt), DW'(16'd1));
`endif

    // Asynchronous reset mid-cycle
    out_ready = 1'b0;
    drive(1'b1, 8'h66); step;
    chk_out("ar_pre", 1'b1, 8'h66, 2'd1);
    #2 rst = 1'b1;
    #1;
    chk_out("ar_now", 1'b0, 8'h00, 2'd0);
    chk("ar_ready", DW'(in_ready), DW'(1'b1));
    drive(1'b1, 8'h99);
    step;
    rst = 1'b0;
    step;
    chk_out("ar_first", 1'b1, 8'h99, 2'd1);
    drive(1'b0, 8'h00);

`ifdef PIPE_STATS_EN
    step; step; step;
    chk("stall_cnt3", DW'(stall_cnt), DW'(16'd3));
    repeat (70000) step;
    chk("stall_sat", DW'(stall_cnt), DW'(16'hFFFF));
    step;
    chk("stall_nowrap", DW'(stall_cnt), DW'(16'hFFFF));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
